// File: rtl/counter_checker.sv
// Monitors a free-running counter stream and reports sequence breaks.
// Lock is lost after a run of mismatches and restored after a run of matches.
module counter_checker #(
    parameter int WIDTH       = 8,
    parameter bit START_ZERO  = 1'b1,
    parameter int LOSS_THRESH = 4,
    parameter int RELOCK      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_LOST  = 2'd2;

    localparam int BAD_W  = (LOSS_THRESH < 1) ? 1 : $clog2(LOSS_THRESH + 1);
    localparam int GOOD_W = (RELOCK < 1) ? 1 : $clog2(RELOCK + 1);

    localparam logic [BAD_W-1:0]  BAD_LIMIT  = BAD_W'(LOSS_THRESH);
    localparam logic [GOOD_W-1:0] GOOD_LIMIT = GOOD_W'(RELOCK);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [WIDTH-1:0]  expected_r;
    logic [WIDTH-1:0]  expected_s;
    logic              err_r;
    logic              err_s;
    logic [7:0]        err_count_r;
    logic [7:0]        err_count_s;
    logic              locked_r;
    logic [BAD_W-1:0]  bad_run_r;
    logic [BAD_W-1:0]  bad_run_s;
    logic [GOOD_W-1:0] good_run_r;
    logic [GOOD_W-1:0] good_run_s;
    logic              match_s;
    logic [7:0]        err_count_inc_s;

    assign match_s = (data == expected_r);

    // Saturating increment of the mismatch counter.
    always_comb begin
        if (err_count_r != 8'hFF) begin
            err_count_inc_s = err_count_r + 8'd1;
        end else begin
            err_count_inc_s = err_count_r;
        end
    end

    // Next-state and next-output logic for one valid sample.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        err_s       = 1'b0;
        err_count_s = err_count_r;
        bad_run_s   = bad_run_r;
        good_run_s  = good_run_r;
        if (valid) begin
            case (state_r)
                S_IDLE: begin
                    expected_s = data + WIDTH'(1);
                    state_s    = S_TRACK;
                    if (START_ZERO && (data != '0)) begin
                        err_s       = 1'b1;
                        err_count_s = err_count_inc_s;
                    end else begin
                        err_s = 1'b0;
                    end
                end
                S_TRACK: begin
                    if (match_s) begin
                        expected_s = expected_r + WIDTH'(1);
                        bad_run_s  = '0;
                    end else begin
                        err_s       = 1'b1;
                        err_count_s = err_count_inc_s;
                        expected_s  = data + WIDTH'(1);
                        if ((bad_run_r + BAD_W'(1)) == BAD_LIMIT) begin
                            state_s    = S_LOST;
                            bad_run_s  = '0;
                            good_run_s = '0;
                        end else begin
                            bad_run_s = bad_run_r + BAD_W'(1);
                        end
                    end
                end
                S_LOST: begin
                    // Always resync while lost; errors are not counted here.
                    expected_s = data + WIDTH'(1);
                    if (match_s) begin
                        if ((good_run_r + GOOD_W'(1)) == GOOD_LIMIT) begin
                            state_s    = S_TRACK;
                            good_run_s = '0;
                        end else begin
                            good_run_s = good_run_r + GOOD_W'(1);
                        end
                    end else begin
                        good_run_s = '0;
                    end
                end
                default: begin
                    state_s    = S_IDLE;
                    expected_s = '0;
                    bad_run_s  = '0;
                    good_run_s = '0;
                end
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            expected_r  <= '0;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
            locked_r    <= 1'b0;
            bad_run_r   <= '0;
            good_run_r  <= '0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            err_r       <= err_s;
            err_count_r <= err_count_s;
            locked_r    <= (state_s == S_TRACK);
            bad_run_r   <= bad_run_s;
            good_run_r  <= good_run_s;
        end
    end

    assign state     = state_r;
    assign expected  = expected_r;
    assign err       = err_r;
    assign err_count = err_count_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker with default parameters (8-bit, start at zero, 4/4 thresholds).
module tb_counter_checker;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] expected;
    logic [1:0] state;

    int n_cmp;
    int n_err;

    counter_checker dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .valid     (valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .expected  (expected),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the edge.
    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        rst   = r;
        valid = v;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  32'(state),     32'd0);
        check({tag, "_exp"},    32'(expected),  32'd0);
        check({tag, "_err"},    32'(err),       32'd0);
        check({tag, "_cnt"},    32'(err_count), 32'd0);
        check({tag, "_locked"}, 32'(locked),    32'd0);
    endtask

    initial begin
        int         err_pulses;
        logic       unlocked_seen;
        logic [7:0] e;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'd0;

        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 8'd9);
        check_reset("rst0");

        // Clean count 0..299 including the 255->0 wrap.
        err_pulses    = 0;
        unlocked_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, i[7:0]);
            if (err) err_pulses++;
            if (!locked) unlocked_seen = 1'b1;
        end
        check("run_err_pulses", 32'(err_pulses), 32'd0);
        check("run_unlocked",   32'(unlocked_seen), 32'd0);
        check("run_cnt",        32'(err_count), 32'd0);
        check("run_exp",        32'(expected), 32'd44);
        check("run_state",      32'(state), 32'd1);

        // Non-zero first sample.
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'd7);
        check("first7_err",   32'(err), 32'd1);
        check("first7_cnt",   32'(err_count), 32'd1);
        check("first7_state", 32'(state), 32'd1);
        check("first7_exp",   32'(expected), 32'd8);
        drive(1'b0, 1'b0, 8'd0);
        check("first7_err_clr", 32'(err), 32'd0);

        // Single jump in TRACK: 0..9, 20, 21, 22.
        drive(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, i[7:0]);
        check("jump_pre_err", 32'(err), 32'd0);
        drive(1'b0, 1'b1, 8'd20);
        check("jump_err",    32'(err), 32'd1);
        check("jump_exp20",  32'(expected), 32'd21);
        drive(1'b0, 1'b1, 8'd21);
        check("jump_err21",  32'(err), 32'd0);
        drive(1'b0, 1'b1, 8'd22);
        check("jump_cnt",    32'(err_count), 32'd1);
        check("jump_exp",    32'(expected), 32'd23);
        check("jump_locked", 32'(locked), 32'd1);

        // Loss after 4 mismatches, relock after 4 matches (with a break in LOST).
        drive(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, i[7:0]);
        drive(1'b0, 1'b1, 8'd50);
        drive(1'b0, 1'b1, 8'd60);
        drive(1'b0, 1'b1, 8'd70);
        check("loss3_state", 32'(state), 32'd1);
        drive(1'b0, 1'b1, 8'd80);
        check("loss_state",  32'(state), 32'd2);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_err",    32'(err), 32'd1);
        check("loss_cnt",    32'(err_count), 32'd4);
        check("loss_exp",    32'(expected), 32'd81);
        drive(1'b0, 1'b1, 8'd81);
        drive(1'b0, 1'b1, 8'd82);
        drive(1'b0, 1'b1, 8'd99);
        check("lost_mis_err", 32'(err), 32'd0);
        check("lost_mis_cnt", 32'(err_count), 32'd4);
        check("lost_mis_exp", 32'(expected), 32'd100);
        drive(1'b0, 1'b1, 8'd100);
        drive(1'b0, 1'b1, 8'd101);
        drive(1'b0, 1'b1, 8'd102);
        check("relock3_state", 32'(state), 32'd2);
        drive(1'b0, 1'b1, 8'd103);
        check("relock_state",  32'(state), 32'd1);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_exp",    32'(expected), 32'd104);

        // Valid gaps hold state.
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'd0);
        drive(1'b0, 1'b0, 8'd55);
        check("gap1_err", 32'(err), 32'd0);
        check("gap1_exp", 32'(expected), 32'd1);
        drive(1'b0, 1'b1, 8'd1);
        drive(1'b0, 1'b0, 8'd77);
        check("gap2_err", 32'(err), 32'd0);
        check("gap2_exp", 32'(expected), 32'd2);
        drive(1'b0, 1'b1, 8'd2);
        check("gap3_err",   32'(err), 32'd0);
        check("gap3_exp",   32'(expected), 32'd3);
        check("gap3_state", 32'(state), 32'd1);

        // Saturation: 300 mismatches each followed by a match.
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'd0);
        e          = 8'd1;
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, e + 8'd100);
            if (err) err_pulses++;
            e = e + 8'd101;
            drive(1'b0, 1'b1, e);
            if (err) err_pulses++;
            e = e + 8'd1;
        end
        check("sat_pulses", 32'(err_pulses), 32'd300);
        check("sat_cnt",    32'(err_count), 32'd255);
        check("sat_state",  32'(state), 32'd1);
        check("sat_exp",    32'(expected), 32'(e));
        drive(1'b1, 1'b1, 8'd33);
        check_reset("rst_sat");
        drive(1'b0, 1'b1, 8'd5);
        check("post_rst_err",   32'(err), 32'd1);
        check("post_rst_state", 32'(state), 32'd1);
        check("post_rst_cnt",   32'(err_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 8: width of the monitored data word.
REQ-002 Parameter START_ZERO, default 1: when 1, the first sample after reset must equal 0.
REQ-003 Parameter LOSS_THRESH, default 4: consecutive mismatches in TRACK that drop lock.
REQ-004 Parameter RELOCK, default 4: consecutive matches in LOST that restore lock.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 data  input  WIDTH  counter value under test.
REQ-008 valid  input  1  data is sampled only on cycles with valid=1.
REQ-009 locked  output  1  high only in TRACK.
REQ-010 err  output  1  one-cycle pulse per counted mismatch.
REQ-011 err_count  output  8  counted mismatches, saturating.
REQ-012 expected  output  WIDTH  next value the checker expects.
REQ-013 state  output  2  IDLE=0, TRACK=1, LOST=2.

Function
REQ-014 All outputs SHALL be registered; each response appears the cycle after the sampling edge.
REQ-015 Cycles with valid=0 SHALL leave all state unchanged, and err SHALL be 0 on the following cycle.
REQ-016 IDLE, valid=1: expected <= data+1; go to TRACK.
REQ-017 IDLE, valid=1, START_ZERO=1 and data!=0: additionally pulse err and increment err_count.
REQ-018 TRACK match (data==expected): expected <= expected+1; bad_run <= 0.
REQ-019 TRACK mismatch: pulse err; increment err_count; expected <= data+1 (resync); bad_run <= bad_run+1.
REQ-020 TRACK mismatch that brings bad_run to LOSS_THRESH: go to LOST; clear bad_run and good_run.
REQ-021 LOST, every valid sample: expected <= data+1; err stays 0; err_count is unchanged.
REQ-022 LOST: a match increments good_run; a mismatch clears good_run to 0.
REQ-023 LOST: the match that brings good_run to RELOCK moves the state to TRACK and clears good_run.
REQ-024 expected SHALL wrap modulo 2^WIDTH, so 2^WIDTH-1 followed by 0 is a match.
REQ-025 err_count SHALL saturate at 255; further mismatches still pulse err.
REQ-026 Matches SHALL never clear err_count; only reset clears it.
REQ-027 bad_run and good_run are internal counters wide enough for their thresholds.

Reset
REQ-028 rst=1 at a rising edge SHALL take priority over valid, regardless of current state.
REQ-029 On that edge: state=IDLE, expected=0, err=0, err_count=0, locked=0, bad_run=0, good_run=0.
REQ-030 While rst=1 the outputs SHALL hold their reset values; data is not sampled.
REQ-031 On the first edge with rst=0, normal sampling resumes from IDLE.

Verification
REQ-032 Reset, then data 0..299 (mod 256) with valid=1 every cycle -> locked=1 from cycle 2; err never pulses; err_count=0 (255->0 wrap is error-free).
REQ-033 Reset, first sample data=7 with START_ZERO=1 -> one err pulse; err_count=1; state=TRACK; expected=8.
REQ-034 In TRACK, send 0..9, 20, 21, 22 -> a single err pulse one cycle after the 20 is sampled; err_count=1; expected=23; locked stays 1.
REQ-035 In TRACK, send 4 consecutive wrong values, then 4 consecutive correct ones -> state=LOST and locked=0 after the 4th mismatch; err_count=4; state=TRACK after the 4th match.
REQ-036 Valid toggles 1/0 during the sequence 0,1,2 -> no err pulses; expected holds its value during the valid=0 gaps.
REQ-037 300 TRACK mismatches spaced by matches, then rst=1 for one cycle -> err_count stops at 255; every output returns to its reset value on the cycle after the reset edge.
